datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Multi-cycle control unit that sequences the 64-bit register-file/ALU/RAM datapath. It accepts 32-bit instructions over a valid/ready handshake and latches each into an internal instruction register (ir). It then drives the datapath control word (addresses, fs, bus enables, memory strobes, status enable, constant k) and the program-counter select for each instruction. It sits between instruction fetch and the datapath, and its outputs connect one-to-one to the datapath's control inputs.

Parameters:
FS_ADD, 5'b01000, ALU function-select code for add, used for address generation.
PS_HOLD, 2'b00, PC select: hold.
PS_INC, 2'b01, PC select: increment.
PS_LOAD, 2'b10, PC select: load.
PS_OFFS, 2'b11, PC select: add offset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
instr  in  32  instruction word.
instr_valid  in  1  instr is valid.
instr_ready  out  1  sequencer can accept an instruction.
status  in  5  datapath status {v,c,n,z,z_imm}.
k  out  64  constant to datapath.
reg_addr, a_addr, b_addr  out  5 each  register-file addresses.
fs  out  5  ALU function select.
reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0  out  1 each  datapath control strobes.
ps  out  2  PC select.
pc_sel  out  1  PC mux select (1 = k).
done  out  1  one-cycle pulse on an instruction's final cycle.
illegal  out  1  one-cycle pulse when an undefined opcode is executed.

Behaviour:
- Instruction fields: op=ir[31:28], f=ir[27:23], rd=ir[22:18], rn=ir[17:13], rm=ir[12:8], imm=ir[7:0].
- Opcodes: 0 NOP, 1 ALUR, 2 ALUI, 3 ALURS, 4 ALUIS, 5 LDR, 6 STR, 7 B, 8 BCOND, 9..15 illegal.
- States: IDLE, EXEC, MADDR, MRD, MWB, MWR. Outputs are Moore: decoded from state and ir only.
- Handshake: instr_ready=1 only in IDLE. An instruction is accepted on a clk edge with instr_valid & instr_ready; ir <= instr.
- From IDLE after accept: op 5 or 6 -> MADDR; any other op -> EXEC. While instr_valid=0, stay in IDLE. instr may change freely outside accept cycles.
- Defaults: every strobe, fs, k, the addresses, ps and pc_sel are 0 unless listed below. ps=PS_HOLD by default.
- Address fields in any non-IDLE state: a_addr=rn, b_addr=rm, reg_addr=rd.
- EXEC, ALUR/ALURS: fs=f, b_sel=0, alu_en=1, reg_w=1. ALURS also sets stat_en=1.
- EXEC, ALUI/ALUIS: same as ALUR/ALURS, but b_sel=1 and k=zero-extended imm.
- EXEC, NOP or illegal: no writes. Illegal also pulses illegal=1.
- EXEC, B: pc_sel=1, k=sign-extended imm, ps=PS_OFFS.
- EXEC, BCOND: condition code cc=rd[2:0] selects the flag: 0 EQ z, 1 NE !z, 2 CS c, 3 CC !c, 4 MI n, 5 PL !n, 6 VS v, 7 VC !v. Flags come from status[4:1] (v=status[4], c=status[3], n=status[2], z=status[1]). Taken -> same outputs as B. Not taken -> ps=PS_INC.
- EXEC -> IDLE, with done=1. In EXEC, every non-branch op drives ps=PS_INC.
- MADDR: fs=FS_ADD, b_sel=1, k=zero-extended imm, mem_en=1. LDR -> MRD; STR -> MWR.
- MRD: mem_r=1, mem_en=1 (synchronous RAM read cycle) -> MWB.
- MWB: chip_sel=1, mem_r=1, reg_w=1, ps=PS_INC, done=1 -> IDLE.
- MWR: b_en=1, mem_w=1, mem_en=1, ps=PS_INC, done=1 -> IDLE.
- Latency, counted from the accept edge to the done cycle: NOP/ALU/branch 1 cycle, STR 2 cycles, LDR 3 cycles. Back-to-back throughput: one instruction per 2/3/4 cycles.
- b_en, alu_en and chip_sel are mutually exclusive in every state; this is a bus-contention invariant, asserted in verification.
- Reset: asserting rst=0 at any time, including mid-instruction, immediately forces state=IDLE, ir=0 and every output to 0, including instr_ready. The in-flight instruction is discarded with no further writes. instr_ready becomes 1 on the first clk edge after rst returns to 1.

Optional Feature:
SEQ_PERF_EN: when defined, adds output ports instr_count[31:0] and cycle_count[31:0]. instr_count increments on each done; cycle_count increments every cycle outside reset. Both clear on reset and wrap at 2^32-1 -> 0. When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset mid-LDR: drop rst in MRD -> all outputs 0 asynchronously; after release, instr_ready=1 on the next edge and no reg_w/mem_w has occurred.
- ALUIS: op=4, f=FS_ADD, rd=3, rn=1, imm=0x85 -> one EXEC cycle with alu_en=1, reg_w=1, stat_en=1, b_sel=1, k=0x85, reg_addr=3, a_addr=1, ps=01, done=1.
- LDR: rd=2, rn=4, imm=0x10 -> MADDR (mem_en=1, k=0x10, fs=FS_ADD), then MRD (mem_r=1), then MWB (chip_sel=1, reg_w=1, done=1); done occurs 3 cycles after the accept edge.
- STR back-to-back with an ALUR held valid: STR completes in MWR (b_en=1, mem_w=1, b_addr=rm); instr_ready is 0 for exactly 2 cycles; the ALUR is accepted on the next edge.
- BCOND NE: with status=5'b00010 -> not taken (ps=01); with status=5'b00000 -> taken (ps=11, pc_sel=1, k=64'hFFFF_FFFF_FFFF_FFFC for imm=0xFC).
- Illegal op=12 -> one EXEC cycle with illegal=1, done=1, no strobes; under SEQ_PERF_EN, instr_count increments by 1.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer that latches instructions and drives the 64-bit datapath control word.
// Optional SEQ_PERF_EN adds instr_count/cycle_count performance counters.
module datapath_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  status,
  output logic [63:0] k,
  output logic [4:0]  reg_addr,
  output logic [4:0]  a_addr,
  output logic [4:0]  b_addr,
  output logic [4:0]  fs,
  output logic        reg_w,
  output logic        b_sel,
  output logic        b_en,
  output logic        alu_en,
  output logic        mem_en,
  output logic        chip_sel,
  output logic        mem_w,
  output logic        mem_r,
  output logic        stat_en,
  output logic        c0,
  output logic [1:0]  ps,
  output logic        pc_sel,
  output logic        done,
  output logic        illegal
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
`endif
);

  localparam int unsigned IW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IMMW = 8;

  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_OFFS = 2'b11;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ALUR  = 4'd1;
  localparam logic [3:0] OP_ALUI  = 4'd2;
  localparam logic [3:0] OP_ALURS = 4'd3;
  localparam logic [3:0] OP_ALUIS = 4'd4;
  localparam logic [3:0] OP_LDR   = 4'd5;
  localparam logic [3:0] OP_STR   = 4'd6;
  localparam logic [3:0] OP_B     = 4'd7;
  localparam logic [3:0] OP_BCOND = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_MADDR = 3'd2,
    S_MRD   = 3'd3,
    S_MWB   = 3'd4,
    S_MWR   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            live_q;
  logic            accept_c;
  logic            taken_c;
  logic            status_unused;

  logic [3:0]      op;
  logic [4:0]      f_fld, rd_fld, rn_fld, rm_fld;
  logic [IMMW-1:0] imm;
  logic            flag_v, flag_c, flag_n, flag_z;

  assign op     = ir_q[31:28];
  assign f_fld  = ir_q[27:23];
  assign rd_fld = ir_q[22:18];
  assign rn_fld = ir_q[17:13];
  assign rm_fld = ir_q[12:8];
  assign imm    = ir_q[7:0];

  assign flag_v = status[4];
  assign flag_c = status[3];
  assign flag_n = status[2];
  assign flag_z = status[1];
  assign status_unused = status[0];

  assign accept_c = instr_valid & instr_ready;
  assign ir_d     = accept_c ? instr : ir_q;

  // live_q holds instr_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if ((instr[31:28] == OP_LDR) || (instr[31:28] == OP_STR)) state_d = S_MADDR;
          else                                                      state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_IDLE;
      S_MADDR: state_d = (op == OP_LDR) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_MWB;
      S_MWB:   state_d = S_IDLE;
      S_MWR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Branch condition from cc = rd[2:0]; odd codes are the negated sense
  always_comb begin
    taken_c = 1'b0;
    case (rd_fld[2:0])
      3'd0: taken_c =  flag_z;
      3'd1: taken_c = ~flag_z;
      3'd2: taken_c =  flag_c;
      3'd3: taken_c = ~flag_c;
      3'd4: taken_c =  flag_n;
      3'd5: taken_c = ~flag_n;
      3'd6: taken_c =  flag_v;
      3'd7: taken_c = ~flag_v;
      default: taken_c = 1'b0;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    k           = '0;
    reg_addr    = '0;
    a_addr      = '0;
    b_addr      = '0;
    fs          = '0;
    reg_w       = 1'b0;
    b_sel       = 1'b0;
    b_en        = 1'b0;
    alu_en      = 1'b0;
    mem_en      = 1'b0;
    chip_sel    = 1'b0;
    mem_w       = 1'b0;
    mem_r       = 1'b0;
    stat_en     = 1'b0;
    c0          = 1'b0;
    ps          = PS_HOLD;
    pc_sel      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;

    if (state_q != S_IDLE) begin
      reg_addr = rd_fld;
      a_addr   = rn_fld;
      b_addr   = rm_fld;
    end

    case (state_q)
      S_IDLE: instr_ready = live_q;
      S_EXEC: begin
        done = 1'b1;
        ps   = PS_INC;
        case (op)
          OP_NOP: ;
          OP_ALUR, OP_ALURS, OP_ALUI, OP_ALUIS: begin
            fs      = f_fld;
            alu_en  = 1'b1;
            reg_w   = 1'b1;
            stat_en = (op == OP_ALURS) || (op == OP_ALUIS);
            if ((op == OP_ALUI) || (op == OP_ALUIS)) begin
              b_sel = 1'b1;
              k     = DW'(imm);
            end
          end
          OP_B, OP_BCOND: begin
            if ((op == OP_B) || taken_c) begin
              pc_sel = 1'b1;
              k      = {{(DW-IMMW){imm[IMMW-1]}}, imm};
              ps     = PS_OFFS;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      // Address generation: rn + zero-extended imm through the ALU
      S_MADDR: begin
        fs     = FS_ADD;
        b_sel  = 1'b1;
        k      = DW'(imm);
        mem_en = 1'b1;
      end
      S_MRD: begin
        mem_r  = 1'b1;
        mem_en = 1'b1;
      end
      S_MWB: begin
        chip_sel = 1'b1;
        mem_r    = 1'b1;
        reg_w    = 1'b1;
        ps       = PS_INC;
        done     = 1'b1;
      end
      S_MWR: begin
        b_en   = 1'b1;
        mem_w  = 1'b1;
        mem_en = 1'b1;
        ps     = PS_INC;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SEQ_PERF_EN
  logic [31:0] instr_count_q, cycle_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_q + 32'(done);
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign instr_count = instr_count_q;
  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: per-instruction control-word sequences from a reference model.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  status;
  logic [63:0] k;
  logic [4:0]  reg_addr, a_addr, b_addr, fs;
  logic        reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0;
  logic [1:0]  ps;
  logic        pc_sel, done, illegal;
`ifdef SEQ_PERF_EN
  logic [31:0] instr_count, cycle_count;
`endif

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .status(status), .k(k), .reg_addr(reg_addr), .a_addr(a_addr), .b_addr(b_addr), .fs(fs),
    .reg_w(reg_w), .b_sel(b_sel), .b_en(b_en), .alu_en(alu_en), .mem_en(mem_en),
    .chip_sel(chip_sel), .mem_w(mem_w), .mem_r(mem_r), .stat_en(stat_en), .c0(c0),
    .ps(ps), .pc_sel(pc_sel), .done(done), .illegal(illegal)
`ifdef SEQ_PERF_EN
    , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
  );

  typedef struct packed {
    logic [63:0] k;
    logic [4:0]  reg_addr, a_addr, b_addr, fs;
    logic        reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, c0;
    logic [1:0]  ps;
    logic        pc_sel, done, illegal;
  } cw_t;

  cw_t act;
  assign act = {k, reg_addr, a_addr, b_addr, fs, reg_w, b_sel, b_en, alu_en, mem_en,
                chip_sel, mem_w, mem_r, stat_en, c0, ps, pc_sel, done, illegal};

  cw_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  rel_edges = 0;
  int  done_seen = 0;
  int  busy;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: the exact sequence of control words an instruction produces, one per busy cycle
  task automatic model(input logic [31:0] ins, input logic [4:0] st);
    int   op;
    logic [4:0] rd;
    logic [7:0] imm;
    logic v, c, n, z, taken;
    cw_t  w, base;
    op  = int'(ins[31:28]);
    rd  = ins[22:18];
    imm = ins[7:0];
    {v, c, n, z} = st[4:1];
    base = '0;
    base.reg_addr = rd;
    base.a_addr   = ins[17:13];
    base.b_addr   = ins[12:8];
    w = base;
    w.done = 1'b1;
    w.ps   = 2'b01;
    if (op == 5 || op == 6) begin
      w = base;
      w.fs = 5'b01000; w.b_sel = 1'b1; w.k = {56'd0, imm}; w.mem_en = 1'b1;
      q.push_back(w);
      w = base;
      if (op == 5) begin
        w.mem_r = 1'b1; w.mem_en = 1'b1;
        q.push_back(w);
        w = base;
        w.chip_sel = 1'b1; w.mem_r = 1'b1; w.reg_w = 1'b1; w.ps = 2'b01; w.done = 1'b1;
      end else begin
        w.b_en = 1'b1; w.mem_w = 1'b1; w.mem_en = 1'b1; w.ps = 2'b01; w.done = 1'b1;
      end
    end else if (op >= 1 && op <= 4) begin
      w.fs = ins[27:23]; w.alu_en = 1'b1; w.reg_w = 1'b1;
      w.stat_en = (op == 3 || op == 4);
      if (op == 2 || op == 4) begin w.b_sel = 1'b1; w.k = {56'd0, imm}; end
    end else if (op == 7 || op == 8) begin
      case (rd[2:0])
        3'd0: taken = z;   3'd1: taken = !z;
        3'd2: taken = c;   3'd3: taken = !c;
        3'd4: taken = n;   3'd5: taken = !n;
        3'd6: taken = v;   default: taken = !v;
      endcase
      if (op == 7 || taken) begin
        w.pc_sel = 1'b1; w.ps = 2'b11; w.k = {{56{imm[7]}}, imm};
      end
    end else if (op >= 9) begin
      w.illegal = 1'b1;
    end
    q.push_back(w);
  endtask

  always @(posedge clk or negedge rst)
    if (!rst) rel_edges <= 0;
    else      rel_edges <= rel_edges + 1;

  // Monitor: idle cycles must be quiet, busy cycles pop and compare the next expected word
  always @(negedge clk) begin
    cw_t exp_w;
    if (rst === 1'b1) begin
      chk("bus_excl", 128'((int'(b_en) + int'(alu_en) + int'(chip_sel)) > 1), 128'd0);
      if (instr_ready === 1'b1) begin
        chk("idle_word", 128'(act), 128'd0);
      end else if (q.size() > 0) begin
        exp_w = q.pop_front();
        chk("ctrl_word", 128'(act), 128'(exp_w));
        if (exp_w.done) done_seen++;
      end else if (rel_edges > 0) begin
        chk("spurious_busy", 128'(act), 128'hdead);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [4:0] st, input bit early, output int nbusy);
    nbusy = 0;
    if (early) begin instr = ins; status = st; instr_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) break;
      nbusy++;
    end
    if (instr_ready !== 1'b1) begin
      chk("ready_timeout", 128'(instr_ready), 128'd1);
      instr_valid = 1'b0;
      return;
    end
    instr = ins; status = st; instr_valid = 1'b1;
    model(ins, st);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  function automatic logic [31:0] mk(input int op, input int f, input int rd, input int rn,
                                     input int rm, input int imm);
    return {4'(op), 5'(f), 5'(rd), 5'(rn), 5'(rm), 8'(imm)};
  endfunction

  initial begin
    logic [31:0] ins;
    rst = 1'b0; instr = '0; instr_valid = 1'b0; status = '0;
    #1;
    chk("reset_word", 128'(act), 128'd0);
    chk("reset_ready", 128'(instr_ready), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_before_edge", 128'(instr_ready), 128'd0);
    @(posedge clk); #1;
    chk("ready_after_release", 128'(instr_ready), 128'd1);

    // ALUIS with zero-extended immediate
    send(mk(4, 8, 3, 1, 0, 8'h85), 5'd0, 1'b0, busy);
    chk("aluis_k", 128'(k), 128'h85);

    // LDR then reset while in MRD
    send(mk(5, 0, 2, 4, 0, 8'h10), 5'd0, 1'b0, busy);
    @(posedge clk); #2;
    chk("ldr_in_mrd", 128'(mem_r), 128'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_word", 128'(act), 128'd0);
    chk("rst_mid_ready", 128'(instr_ready), 128'd0);
    q.delete();
    done_seen = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk("rel_ready_low", 128'(instr_ready), 128'd0);
    @(posedge clk); #1;
    chk("rel_ready_high", 128'(instr_ready), 128'd1);

    // STR with an ALUR held valid behind it
    send(mk(6, 0, 7, 9, 21, 8'h33), 5'd0, 1'b0, busy);
    send(mk(1, 5, 6, 2, 3, 0), 5'd0, 1'b1, busy);
    chk("str_busy_cycles", 128'(busy), 128'd2);

    // BCOND NE not taken, then taken with negative offset
    send(mk(8, 0, 1, 0, 0, 8'hFC), 5'b00010, 1'b0, busy);
    chk("bne_nt_ps", 128'(ps), 128'd1);
    send(mk(8, 0, 1, 0, 0, 8'hFC), 5'b00000, 1'b0, busy);
    chk("bne_t_k", 128'(k), 128'hFFFF_FFFF_FFFF_FFFC);
    chk("bne_t_ps", 128'(ps), 128'd3);

    // Illegal opcode
    send(mk(12, 3, 4, 5, 6, 8'h77), 5'd0, 1'b0, busy);
    chk("illegal_pulse", 128'(illegal), 128'd1);

    // Randomized stream with idle gaps
    for (int i = 0; i < 200; i++) begin
      ins = $urandom;
      ins[31:28] = 4'($urandom_range(0, 10));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(ins, 5'($urandom), 1'b0, busy);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("drain", 128'(q.size()), 128'd0);
    @(posedge clk);
    @(negedge clk);
`ifdef SEQ_PERF_EN
    chk("instr_count", 128'(instr_count), 128'(done_seen));
    chk("cycle_count", 128'(cycle_count), 128'(rel_edges));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
